// File: rtl/delay_slot_pkg.sv
// Shared types and helpers for the delay-slot arbiter: stage tag record and
// delay normalisation (a programmed delay of 0 behaves as 1).
package delay_slot_pkg;
   localparam int ID_W    = 1;
   localparam int DELAY_W = 2;
   localparam int STAGES  = 3;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } stage_tag_t;

   function automatic logic [DELAY_W-1:0] norm_delay(input logic [DELAY_W-1:0] d);
      return (d == '0) ? DELAY_W'(1) : d;
   endfunction
endpackage

// File: rtl/delay_slot_pipe.sv
// Three-stage shift pipeline with a single insertion point per cycle.
// The stage at insert_idx is overwritten by the new item instead of shifting.
module delay_slot_pipe
   import delay_slot_pkg::*;
#(
   parameter int DATA_WIDTH = 8
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  insert_en,
   input  logic [1:0]            insert_idx,
   input  logic [ID_W-1:0]       insert_id,
   input  logic [DATA_WIDTH-1:0] insert_data,
   output logic [STAGES-1:0]     stage_valid,
   output logic [ID_W-1:0]       s0_id,
   output logic [DATA_WIDTH-1:0] s0_data
);
   stage_tag_t            s0_tag, s1_tag, s2_tag;
   logic [DATA_WIDTH-1:0] s0_dat, s1_dat, s2_dat;
   stage_tag_t            ins_tag;

   assign ins_tag = '{valid: 1'b1, id: insert_id};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s0_tag <= '0;
         s1_tag <= '0;
         s2_tag <= '0;
         s0_dat <= '0;
         s1_dat <= '0;
         s2_dat <= '0;
      end else begin
         // s2 -> s1 -> s0 shift; the slot chosen by the arbiter takes the new item
         if (insert_en && insert_idx == 2'd0) begin
            s0_tag <= ins_tag;
            s0_dat <= insert_data;
         end else begin
            s0_tag <= s1_tag;
            s0_dat <= s1_dat;
         end
         if (insert_en && insert_idx == 2'd1) begin
            s1_tag <= ins_tag;
            s1_dat <= insert_data;
         end else begin
            s1_tag <= s2_tag;
            s1_dat <= s2_dat;
         end
         if (insert_en && insert_idx == 2'd2) begin
            s2_tag <= ins_tag;
            s2_dat <= insert_data;
         end else begin
            s2_tag <= '0;
            s2_dat <= '0;
         end
      end
   end

   assign stage_valid = {s2_tag.valid, s1_tag.valid, s0_tag.valid};
   assign s0_id       = s0_tag.id;
   assign s0_data     = s0_dat;
endmodule

// File: rtl/delay_slot_arbiter.sv
// Two-requester round-robin arbiter sharing one variable-latency (1-3 cycle)
// delay pipeline. Optional counters enabled by DELAY_SLOT_ARBITER_STATS_EN.
module delay_slot_arbiter
   import delay_slot_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_DELAY  = 3
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [DATA_WIDTH-1:0] req0_data,
   input  logic [DELAY_W-1:0]    req0_delay,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [DATA_WIDTH-1:0] req1_data,
   input  logic [DELAY_W-1:0]    req1_delay,
   output logic                  req1_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_id
`ifdef DELAY_SLOT_ARBITER_STATS_EN
   ,
   input  logic                  stats_clr,
   output logic [15:0]           grant_cnt0,
   output logic [15:0]           grant_cnt1,
   output logic [15:0]           stall_cnt
`endif
);
   logic [DELAY_W-1:0]    d0, d1, ins_delay;
   logic [STAGES-1:0]     stage_valid;
   logic                  elig0, elig1, grant0, grant1;
   logic                  ptr_q;
   logic [1:0]            ins_idx;
   logic [ID_W-1:0]       ins_id;
   logic [DATA_WIDTH-1:0] ins_data;
   logic [ID_W-1:0]       s0_id;

   // A delay-d item lands in s[d-1]; the stage that would shift into it must be empty.
   function automatic logic slot_free(input logic [DELAY_W-1:0] d,
                                      input logic [STAGES-1:0]  v);
      case (d)
         2'd1:    return !v[1];
         2'd2:    return !v[2];
         default: return d == DELAY_W'(MAX_DELAY);
      endcase
   endfunction

   always_comb begin
      d0        = norm_delay(req0_delay);
      d1        = norm_delay(req1_delay);
      elig0     = req0_valid && slot_free(d0, stage_valid);
      elig1     = req1_valid && slot_free(d1, stage_valid);
      grant0    = elig0 && (!elig1 || !ptr_q);
      grant1    = elig1 && (!elig0 ||  ptr_q);
      ins_delay = grant1 ? d1 : d0;
      ins_idx   = ins_delay - 2'd1;
      ins_id    = ID_W'(grant1);
      ins_data  = grant1 ? req1_data : req0_data;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      ptr_q <= 1'b0;
      else if (grant0) ptr_q <= 1'b1;
      else if (grant1) ptr_q <= 1'b0;
   end

   delay_slot_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_pipe (
      .clk         (clk),
      .reset       (reset),
      .insert_en   (grant0 || grant1),
      .insert_idx  (ins_idx),
      .insert_id   (ins_id),
      .insert_data (ins_data),
      .stage_valid (stage_valid),
      .s0_id       (s0_id),
      .s0_data     (out_data)
   );

   assign out_valid = stage_valid[0];
   assign out_id    = s0_id[0];

`ifdef DELAY_SLOT_ARBITER_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
      return (en && c != 16'hFFFF) ? c + 16'd1 : c;
   endfunction

   logic stall;
   assign stall = (req0_valid || req1_valid) && !(grant0 || grant1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
         stall_cnt  <= '0;
      end else if (stats_clr) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
         stall_cnt  <= '0;
      end else begin
         grant_cnt0 <= sat_inc(grant_cnt0, grant0);
         grant_cnt1 <= sat_inc(grant_cnt1, grant1);
         stall_cnt  <= sat_inc(stall_cnt, stall);
      end
   end
`endif
endmodule

// File: tb/tb_delay_slot_arbiter.sv
// Directed bench for delay_slot_arbiter; stats ports connected and checked
// when DELAY_SLOT_ARBITER_STATS_EN is defined.
module tb_delay_slot_arbiter;
   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic [1:0] req0_delay, req1_delay;
   logic       req0_ready, req1_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_id;
   int         total = 0;
   int         bad   = 0;
`ifdef DELAY_SLOT_ARBITER_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

   always #5 clk = ~clk;

   delay_slot_arbiter #(.DATA_WIDTH(8), .MAX_DELAY(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_delay (req0_delay),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_delay (req1_delay),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_id     (out_id)
`ifdef DELAY_SLOT_ARBITER_STATS_EN
      ,
      .stats_clr  (stats_clr),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1),
      .stall_cnt  (stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic v, input logic [7:0] d, input logic [1:0] dl);
      req0_valid = v;
      req0_data  = d;
      req0_delay = dl;
   endtask

   task automatic drv1(input logic v, input logic [7:0] d, input logic [1:0] dl);
      req1_valid = v;
      req1_data  = d;
      req1_delay = dl;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic id);
      chk({tag, "_valid"}, 16'(out_valid), 16'(v));
      if (v) begin
         chk({tag, "_data"}, 16'(out_data), 16'(d));
         chk({tag, "_id"},   16'(out_id),   16'(id));
      end
   endtask

   initial begin
      reset = 1'b0;
      drv0(1'b0, 8'h00, 2'd0);
      drv1(1'b0, 8'h00, 2'd0);
      #12;
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_out_data",  16'(out_data),  16'd0);
      chk("rst_out_id",    16'(out_id),    16'd0);
      reset = 1'b1;
      tick();

      // 1: single d=1 item
      drv0(1'b1, 8'hA5, 2'd1);
      #1;
      chk("t1_ready0", 16'(req0_ready), 16'd1);
      chk("t1_ready1", 16'(req1_ready), 16'd0);
      tick();
      drv0(1'b0, 8'h00, 2'd0);
      chk_out("t1_out", 1'b1, 8'hA5, 1'b0);
      tick();
      chk("t1_gone", 16'(out_valid), 16'd0);

      // 2: d=3 item blocks a later d=1 request for one cycle
      drv0(1'b1, 8'h11, 2'd3);
      #1;
      chk("t2_ready0", 16'(req0_ready), 16'd1);
      tick();
      drv0(1'b0, 8'h00, 2'd0);
      tick();
      drv1(1'b1, 8'h22, 2'd1);
      #1;
      chk("t2_ready1_busy", 16'(req1_ready), 16'd0);
      tick();
      chk_out("t2_out_a", 1'b1, 8'h11, 1'b0);
      chk("t2_ready1_free", 16'(req1_ready), 16'd1);
      tick();
      drv1(1'b0, 8'h00, 2'd0);
      chk_out("t2_out_b", 1'b1, 8'h22, 1'b1);
      tick();
      chk("t2_gone", 16'(out_valid), 16'd0);
`ifdef DELAY_SLOT_ARBITER_STATS_EN
      chk("t2_gcnt0", grant_cnt0, 16'd2);
      chk("t2_gcnt1", grant_cnt1, 16'd1);
      chk("t2_stall", stall_cnt,  16'd1);
`endif

      // 3: both requesting d=2 every cycle alternate from pointer 0
      drv0(1'b1, 8'hB0, 2'd2);
      drv1(1'b1, 8'hC1, 2'd2);
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("t3_ready0_%0d", k), 16'(req0_ready), 16'((k % 2) == 0));
         chk($sformatf("t3_ready1_%0d", k), 16'(req1_ready), 16'((k % 2) == 1));
         tick();
         if (k >= 1)
            chk_out($sformatf("t3_out_%0d", k), 1'b1,
                    ((k - 1) % 2 == 1) ? 8'hC1 : 8'hB0, 1'((k - 1) % 2));
      end
      drv0(1'b0, 8'h00, 2'd0);
      drv1(1'b0, 8'h00, 2'd0);
      tick();
      chk_out("t3_out_last", 1'b1, 8'hC1, 1'b1);
      tick();
      chk("t3_gone", 16'(out_valid), 16'd0);

      // 4: delay 0 behaves as 1
      drv1(1'b1, 8'h3C, 2'd0);
      #1;
      chk("t4_ready1", 16'(req1_ready), 16'd1);
      tick();
      drv1(1'b0, 8'h00, 2'd0);
      chk_out("t4_out", 1'b1, 8'h3C, 1'b1);
      tick();
      chk("t4_gone", 16'(out_valid), 16'd0);

      // 6: back-to-back d=2 stream, in order with no gaps
      for (int k = 0; k < 16; k++) begin
         drv0(1'b1, 8'(k), 2'd2);
         #1;
         chk($sformatf("t6_ready_%0d", k), 16'(req0_ready), 16'd1);
         tick();
         if (k >= 1)
            chk_out($sformatf("t6_out_%0d", k), 1'b1, 8'(k - 1), 1'b0);
      end
      drv0(1'b0, 8'h00, 2'd0);
      tick();
      chk_out("t6_out_15", 1'b1, 8'h0F, 1'b0);
      tick();
      chk("t6_gone", 16'(out_valid), 16'd0);

      // 5: fill s0..s2, then asynchronous reset mid-cycle
      for (int k = 0; k < 3; k++) begin
         drv0(1'b1, 8'(8'h51 + k), 2'd3);
         tick();
      end
      drv0(1'b0, 8'h00, 2'd0);
      chk_out("t5_full", 1'b1, 8'h51, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("t5_rst_valid", 16'(out_valid), 16'd0);
      chk("t5_rst_data",  16'(out_data),  16'd0);
      chk("t5_rst_id",    16'(out_id),    16'd0);
      #10;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("t5_stale_%0d", k), 16'(out_valid), 16'd0);
      end
      drv0(1'b1, 8'h61, 2'd1);
      drv1(1'b1, 8'h62, 2'd1);
      #1;
      chk("t5_ready0", 16'(req0_ready), 16'd1);
      chk("t5_ready1", 16'(req1_ready), 16'd0);
      tick();
      drv0(1'b0, 8'h00, 2'd0);
      drv1(1'b0, 8'h00, 2'd0);
      chk_out("t5_out", 1'b1, 8'h61, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
